// File: rtl/tetris_soc_debug_monitor_mem_pkg.sv
// Shared definitions for the debug monitor RAM: FSM states, jdo field offsets,
// and the one-entry JTAG command record.
package tetris_soc_debug_monitor_mem_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DEPTH_DEF    = 256;
  localparam int JDO_ADDR_LSB = 26;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_J_RD,
    ST_J_RDCAP,
    ST_J_WR,
    ST_C_RD,
    ST_C_RDCAP,
    ST_C_WR
  } state_e;

  typedef struct packed {
    logic        vld;
    logic        wr;
    logic [31:0] data;
  } jtag_cmd_t;

endpackage

// File: rtl/tetris_soc_debug_monitor_ram.sv
// Single-port DEPTH x 32 RAM with byte enables and 1-cycle synchronous read.
// Contents are deliberately not reset.
module tetris_soc_debug_monitor_ram #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/tetris_soc_debug_monitor_mem.sv
// Debug monitor memory: arbitrates JTAG (via a one-entry pending command) and
// CPU Avalon-MM accesses onto a single-port RAM.
module tetris_soc_debug_monitor_mem
  import tetris_soc_debug_monitor_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  output logic              cmd_overrun
);

  state_e            state_q, state_d;
  jtag_cmd_t         pend_q, pend_d;
  logic [31:0]       op_data_q, op_data_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       cpu_rd_q, cpu_rd_d;
  logic              ovr_q, ovr_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              jtag_req, consume, accept;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

  assign jtag_req = take_action_ocimem_b | take_no_action_ocimem_a;
  assign consume  = (state_q == ST_IDLE) && pend_q.vld;
  // The entry being dispatched this cycle frees its slot for a new strobe.
  assign accept   = !pend_q.vld || consume;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    op_data_d = op_data_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    cpu_rd_d  = cpu_rd_q;
    ovr_d     = ovr_q;
    ram_addr  = mon_a_q;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = op_data_q;

    if (consume) begin
      pend_d.vld = 1'b0;
      op_data_d  = pend_q.data;
    end
    if (jtag_req) begin
      if (accept) begin
        pend_d.vld  = 1'b1;
        pend_d.wr   = take_action_ocimem_b;
        pend_d.data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q.vld)     state_d = pend_q.wr ? ST_J_WR : ST_J_RD;
        else if (cpu_read)  state_d = ST_C_RD;
        else if (cpu_write) state_d = ST_C_WR;
      end
      ST_J_RD:    state_d = ST_J_RDCAP;
      ST_J_RDCAP: begin
        mon_d_d = ram_rdata;
        state_d = ST_IDLE;
      end
      ST_J_WR: begin
        ram_we  = 1'b1;
        mon_d_d = op_data_q;
        state_d = ST_IDLE;
      end
      ST_C_RD: begin
        ram_addr = cpu_address;
        state_d  = ST_C_RDCAP;
      end
      ST_C_RDCAP: begin
        cpu_rd_d = ram_rdata;
        state_d  = ST_IDLE;
      end
      ST_C_WR: begin
        ram_addr  = cpu_address;
        ram_we    = 1'b1;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An address load overrides the post-access increment.
    if (take_action_ocimem_a)
      mon_a_d = jdo[JDO_ADDR_LSB +: ADDR_W];
    else if (state_q == ST_J_RDCAP || state_q == ST_J_WR)
      mon_a_d = (mon_a_q == ADDR_W'(DEPTH-1)) ? '0 : mon_a_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      op_data_q <= '0;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      cpu_rd_q  <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      op_data_q <= op_data_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      cpu_rd_q  <= cpu_rd_d;
      ovr_q     <= ovr_d;
    end
  end

  tetris_soc_debug_monitor_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .be_i   (ram_be),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  // RAM output is live during the capture cycle; the register holds it afterwards.
  assign cpu_readdata    = (state_q == ST_C_RDCAP) ? ram_rdata : cpu_rd_q;
  assign cpu_waitrequest = (cpu_read | cpu_write) & ~reset &
                           ~(state_q == ST_C_RDCAP || state_q == ST_C_WR);
  assign jtag_busy       = pend_q.vld ||
                           state_q == ST_J_RD || state_q == ST_J_RDCAP || state_q == ST_J_WR;
  assign MonDReg         = mon_d_q;
  assign MonAReg         = mon_a_q;
  assign cmd_overrun     = ovr_q;

endmodule

// File: tb/tb_tetris_soc_debug_monitor_mem.sv
// Randomized scoreboard bench for the debug monitor memory against an
// array-based model of RAM, MonAReg and MonDReg.
module tb_tetris_soc_debug_monitor_mem;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_a, take_b, take_na;
  logic [AW-1:0] cpu_address;
  logic          cpu_read, cpu_write;
  logic [31:0]   cpu_writedata;
  logic [3:0]    cpu_byteenable;
  logic [31:0]   cpu_readdata, MonDReg;
  logic          cpu_waitrequest, jtag_busy, cmd_overrun;
  logic [AW-1:0] MonAReg;

  always #5 clk = ~clk;

  tetris_soc_debug_monitor_mem #(.ADDR_W(AW), .DEPTH(256)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .jdo                    (jdo),
    .take_action_ocimem_a   (take_a),
    .take_action_ocimem_b   (take_b),
    .take_no_action_ocimem_a(take_na),
    .cpu_address            (cpu_address),
    .cpu_read               (cpu_read),
    .cpu_write              (cpu_write),
    .cpu_writedata          (cpu_writedata),
    .cpu_byteenable         (cpu_byteenable),
    .cpu_readdata           (cpu_readdata),
    .cpu_waitrequest        (cpu_waitrequest),
    .MonDReg                (MonDReg),
    .MonAReg                (MonAReg),
    .jtag_busy              (jtag_busy),
    .cmd_overrun            (cmd_overrun)
  );

  typedef struct packed { logic [31:0] d; logic [7:0] a; } jexp_t;

  int          nvec = 0, nerr = 0;
  logic [31:0] mem [256];
  logic [7:0]  ma;
  logic [31:0] md;
  jexp_t       jq[$];
  logic [31:0] cq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: CPU read completions and ends of JTAG busy episodes.
  logic  busy_prev = 1'b0;
  jexp_t je;
  logic [31:0] ce;
  always @(negedge clk) begin
    if (cpu_read && !cpu_waitrequest) begin
      if (cq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL cpu_rd_unexpected: got completion with data 0x%0h, expected none", cpu_readdata);
      end else begin
        ce = cq.pop_front();
        chk("cpu_readdata", cpu_readdata, ce);
      end
    end
    if (busy_prev && !jtag_busy) begin
      if (jq.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL jtag_unexpected: got busy end MonDReg=0x%0h, expected none", MonDReg);
      end else begin
        je = jq.pop_front();
        chk("MonDReg", MonDReg, je.d);
        chk("MonAReg", MonAReg, je.a);
      end
    end
    busy_prev = jtag_busy;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // kind 0: address load, 1: JTAG write, 2: JTAG read. Holds strobe one cycle.
  task automatic pulse(input int kind, input logic [31:0] val);
    logic [63:0] r;
    r   = {$urandom(), $urandom()};
    jdo = r[37:0];
    case (kind)
      0:       begin jdo[33:26] = val[7:0]; take_a = 1'b1; end
      1:       begin jdo[34:3]  = val;      take_b = 1'b1; end
      default: take_na = 1'b1;
    endcase
    tick();
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (jtag_busy && n < 30) begin tick(); n++; end
    if (jtag_busy) begin
      nvec++; nerr++;
      $display("FAIL %s: got jtag_busy=1 after 30 cycles, expected 0", nm);
    end
    tick();
  endtask

  task automatic j_load(input logic [7:0] a);
    pulse(0, {24'h0, a});
    ma = a;
    chk("MonAReg_load", MonAReg, a);
  endtask

  task automatic j_write(input logic [31:0] d);
    mem[ma] = d; md = d; ma = ma + 8'd1;
    jq.push_back('{d: md, a: ma});
    pulse(1, d);
    wait_idle("jtag_wr");
  endtask

  task automatic j_read();
    md = mem[ma]; ma = ma + 8'd1;
    jq.push_back('{d: md, a: ma});
    pulse(2, 0);
    wait_idle("jtag_rd");
  endtask

  // Returns the number of sampled cycles with waitrequest high.
  task automatic cpu_wait(input string nm, output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!cpu_waitrequest) break;
      n++;
    end
    if (n >= 20) begin
      nvec++; nerr++;
      $display("FAIL %s: got waitrequest stuck high, expected completion", nm);
    end
    tick();
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic c_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    for (int b = 0; b < 4; b++) if (be[b]) mem[a][b*8 +: 8] = d[b*8 +: 8];
    cpu_address = a; cpu_writedata = d; cpu_byteenable = be; cpu_write = 1'b1;
    cpu_wait("cpu_wr", n);
    chk("cpu_wr_wait", n, 1);
  endtask

  task automatic c_read(input logic [7:0] a, input bit also_wr, output int n);
    cq.push_back(mem[a]);
    cpu_address = a; cpu_read = 1'b1; cpu_write = also_wr;
    cpu_writedata = $urandom(); cpu_byteenable = 4'hF;
    cpu_wait("cpu_rd", n);
  endtask

  task automatic conc(input logic [7:0] a);
    int n;
    md = mem[ma]; ma = ma + 8'd1;
    jq.push_back('{d: md, a: ma});
    pulse(2, 0);
    c_read(a, 1'b0, n);
    chk("conc_wait_ge4", n >= 4, 1);
    wait_idle("conc");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] a;
    reset = 1'b1; jdo = '0; take_a = 0; take_b = 0; take_na = 0;
    cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0; cpu_byteenable = '0;
    ma = 0; md = 0;
    repeat (3) tick();
    chk("rst_MonAReg", MonAReg, 0);
    chk("rst_MonDReg", MonDReg, 0);
    chk("rst_cpu_readdata", cpu_readdata, 0);
    chk("rst_waitrequest", cpu_waitrequest, 0);
    chk("rst_jtag_busy", jtag_busy, 0);
    chk("rst_cmd_overrun", cmd_overrun, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) c_write(8'(i), 32'h0, 4'hF);

    j_load(8'h10); j_write(32'hDEADBEEF);
    chk("wr_MonAReg_11", MonAReg, 8'h11);
    c_read(8'h10, 1'b0, n); chk("cpu_rd_wait", n, 2);
    j_load(8'h10); j_read();
    chk("rd_MonDReg_beef", MonDReg, 32'hDEADBEEF);
    j_load(8'hFF); j_write($urandom());
    chk("MonAReg_wrap", MonAReg, 0);
    c_write(8'd5, 32'h12345678, 4'b0011);
    c_read(8'd5, 1'b0, n); chk("cpu_rd5_wait", n, 2);
    c_read(8'd5, 1'b1, n); chk("cpu_rdwr_wait", n, 2);
    j_load(8'h10); conc(8'd5);

    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 1) ? ma : 8'($urandom_range(0, 255));
      case ($urandom_range(0, 6))
        0: j_load(8'($urandom_range(0, 255)));
        1: j_write($urandom());
        2: j_read();
        3: c_write(a, $urandom(), 4'($urandom_range(0, 15)));
        4: begin c_read(a, 1'b0, n); chk("cpu_rd_wait", n, 2); end
        5: conc(a);
        default: begin c_read(a, 1'b1, n); chk("cpu_rdwr_wait", n, 2); end
      endcase
    end

    // Three back-to-back reads: first two execute, third is dropped.
    chk("overrun_before", cmd_overrun, 0);
    md = mem[ma + 8'd1]; ma = ma + 8'd2;
    jq.push_back('{d: md, a: ma});
    pulse(2, 0); pulse(2, 0); pulse(2, 0);
    wait_idle("overrun");
    chk("overrun_after", cmd_overrun, 1);

    // Reset while in J_RD.
    j_load(8'h20);
    jq.push_back('{d: 32'h0, a: 8'h0});
    pulse(2, 0); tick();
    reset = 1'b1; #1;
    chk("rst_jrd_MonDReg", MonDReg, 0);
    chk("rst_jrd_MonAReg", MonAReg, 0);
    chk("rst_jrd_busy", jtag_busy, 0);
    chk("rst_jrd_overrun", cmd_overrun, 0);
    tick(); reset = 1'b0; ma = 0; md = 0; tick();

    // Reset while in J_WR must abandon the write.
    j_load(8'h30);
    jq.push_back('{d: 32'h0, a: 8'h0});
    pulse(1, ~mem[8'h30]); tick();
    reset = 1'b1;
    tick(); reset = 1'b0; ma = 0; md = 0; tick();
    c_read(8'h30, 1'b0, n); chk("cpu_rd_after_rst", n, 2);
    c_read(8'h20, 1'b0, n); chk("cpu_rd_after_rst", n, 2);

    repeat (3) tick();
    chk("jq_drained", jq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
